// File: rtl/rob_recovery_fsm.sv
// rob_recovery_fsm
// Branch-mispredict recovery sequencer for the reorder buffer.
// A mispredict causes one ROLLBACK cycle, which flushes the front end,
// redirects the PC and restores the ROB tail. It is followed by a WALK phase.
// The WALK phase replays the surviving entries, from the head through the
// mispredicting entry, two per cycle, so that the rename map can be rebuilt.
// An older mispredict that arrives mid-sequence restarts the recovery.
// A younger or equal mispredict is dropped.

package common;

    // rob_state encodings consumed by the pipeline stall/flush logic
    typedef enum logic [1:0] {
        rob_idle     = 2'b00,
        rob_rollback = 2'b01,
        rob_walk     = 2'b10
    } rob_state_e;

endpackage

module rob_recovery_fsm
    import common::*;
#(
    parameter int ROB_DEPTH = 16,
    parameter int ROB_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 mispredict_valid,
    input  logic [ROB_IDX_W-1:0] mispredict_rob_idx,
    input  logic [31:0]          mispredict_target,
    input  logic [ROB_IDX_W-1:0] rob_head,
    output logic [1:0]           rob_state,
    output logic                 flush_valid,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,
    output logic                 tail_restore_valid,
    output logic [ROB_IDX_W-1:0] tail_restore_idx,
    output logic [1:0]           walk_valid,
    output logic [ROB_IDX_W-1:0] walk_idx0,
    output logic [ROB_IDX_W-1:0] walk_idx1
);

    // The walk count and the index arithmetic rely on the ROB wrapping
    // naturally at the index width.
    if (ROB_DEPTH != (1 << ROB_IDX_W)) begin : g_bad_depth
        $error("rob_recovery_fsm: ROB_DEPTH must equal 2**ROB_IDX_W");
    end

    localparam logic [ROB_IDX_W-1:0] IDX_ONE  = ROB_IDX_W'(1);
    localparam logic [ROB_IDX_W-1:0] IDX_TWO  = ROB_IDX_W'(2);
    localparam logic [ROB_IDX_W-1:0] IDX_ZERO = ROB_IDX_W'(0);
    localparam logic [ROB_IDX_W:0]   CNT_ZERO = (ROB_IDX_W + 1)'(0);
    localparam logic [ROB_IDX_W:0]   CNT_ONE  = (ROB_IDX_W + 1)'(1);
    localparam logic [ROB_IDX_W:0]   CNT_TWO  = (ROB_IDX_W + 1)'(2);

    // Age of an entry relative to the ROB head. It is a wrapping subtract,
    // so 0 is the oldest entry.
    function automatic logic [ROB_IDX_W-1:0] rob_age(
        input logic [ROB_IDX_W-1:0] idx,
        input logic [ROB_IDX_W-1:0] head
    );
        return idx - head;
    endfunction

    // state and sequence bookkeeping
    rob_state_e            state_q, state_d;
    logic [ROB_IDX_W-1:0]  idx_q, idx_d;        // latched mispredict index
    logic [ROB_IDX_W:0]    rem_q, rem_d;        // entries still to walk
    logic [ROB_IDX_W-1:0]  ptr_q, ptr_d;        // next entry to walk

    // registered outputs
    logic                  pulse_q, pulse_d;    // flush/redirect/tail-restore
    logic [31:0]           pc_q, pc_d;
    logic [ROB_IDX_W-1:0]  tail_q, tail_d;
    logic [1:0]            wv_q, wv_d;
    logic [ROB_IDX_W-1:0]  widx0_q, widx0_d;
    logic [ROB_IDX_W-1:0]  widx1_q, widx1_d;

    logic [ROB_IDX_W-1:0]  new_age_s;
    logic [ROB_IDX_W-1:0]  cur_age_s;
    logic                  accept_s;

    // Decide whether the incoming mispredict starts a new sequence.
    // The head is stable while a sequence is in flight, so ages taken
    // against the current head are comparable.
    always_comb begin
        new_age_s = rob_age(mispredict_rob_idx, rob_head);
        cur_age_s = rob_age(idx_q, rob_head);
        accept_s  = 1'b0;
        case (state_q)
            rob_idle: begin
                if (mispredict_valid) begin
                    accept_s = 1'b1;
                end else begin
                    accept_s = 1'b0;
                end
            end
            rob_rollback, rob_walk: begin
                // Only a strictly older branch restarts the recovery.
                // A repeat of the same index is therefore ignored.
                if (mispredict_valid && (new_age_s < cur_age_s)) begin
                    accept_s = 1'b1;
                end else begin
                    accept_s = 1'b0;
                end
            end
            default: begin
                accept_s = 1'b0;
            end
        endcase
    end

    // Next-state and next-output logic. Every output is computed one cycle
    // ahead, so that the state register and the outputs change together.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        ptr_d   = ptr_q;
        pc_d    = pc_q;
        tail_d  = tail_q;
        pulse_d = 1'b0;
        wv_d    = 2'b00;
        widx0_d = widx0_q;
        widx1_d = widx1_q;

        if (accept_s) begin
            // Start, or restart, the sequence. The walk count is age + 1,
            // which can reach ROB_DEPTH and needs the extra bit.
            state_d = rob_rollback;
            idx_d   = mispredict_rob_idx;
            rem_d   = {1'b0, new_age_s} + CNT_ONE;
            ptr_d   = rob_head;
            pc_d    = mispredict_target;
            tail_d  = mispredict_rob_idx + IDX_ONE;
            pulse_d = 1'b1;
        end else begin
            case (state_q)
                rob_idle: begin
                    state_d = rob_idle;
                end
                rob_rollback, rob_walk: begin
                    if (rem_q == CNT_ZERO) begin
                        // The cycle that emitted the last entry is ending.
                        state_d = rob_idle;
                    end else begin
                        state_d = rob_walk;
                        if (rem_q >= CNT_TWO) begin
                            wv_d  = 2'b11;
                            rem_d = rem_q - CNT_TWO;
                        end else begin
                            wv_d  = 2'b01;
                            rem_d = CNT_ZERO;
                        end
                        widx0_d = ptr_q;
                        widx1_d = ptr_q + IDX_ONE;
                        ptr_d   = ptr_q + IDX_TWO;
                    end
                end
                default: begin
                    // An illegal encoding recovers to a clean idle state.
                    state_d = rob_idle;
                    rem_d   = CNT_ZERO;
                    ptr_d   = IDX_ZERO;
                end
            endcase
        end
    end

    // State and output registers, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= rob_idle;
            idx_q   <= IDX_ZERO;
            rem_q   <= CNT_ZERO;
            ptr_q   <= IDX_ZERO;
            pulse_q <= 1'b0;
            pc_q    <= 32'h0000_0000;
            tail_q  <= IDX_ZERO;
            wv_q    <= 2'b00;
            widx0_q <= IDX_ZERO;
            widx1_q <= IDX_ZERO;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            ptr_q   <= ptr_d;
            pulse_q <= pulse_d;
            pc_q    <= pc_d;
            tail_q  <= tail_d;
            wv_q    <= wv_d;
            widx0_q <= widx0_d;
            widx1_q <= widx1_d;
        end
    end

    assign rob_state          = state_q;
    assign flush_valid        = pulse_q;
    assign redirect_valid     = pulse_q;
    assign tail_restore_valid = pulse_q;
    assign redirect_pc        = pc_q;
    assign tail_restore_idx   = tail_q;
    assign walk_valid         = wv_q;
    assign walk_idx0          = widx0_q;
    assign walk_idx1          = widx1_q;

endmodule

// File: tb/tb_rob_recovery_fsm.sv
// Scoreboard bench for rob_recovery_fsm.
// Stimulus pushes hand-computed expected output cycles into a queue. A
// monitor pops and compares one entry every cycle in which the DUT presents
// a non-idle output.
module tb_rob_recovery_fsm;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mispredict_valid;
    logic [3:0]  mispredict_rob_idx;
    logic [31:0] mispredict_target;
    logic [3:0]  rob_head;
    logic [1:0]  rob_state;
    logic        flush_valid;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        tail_restore_valid;
    logic [3:0]  tail_restore_idx;
    logic [1:0]  walk_valid;
    logic [3:0]  walk_idx0;
    logic [3:0]  walk_idx1;

    rob_recovery_fsm #(.ROB_DEPTH(16), .ROB_IDX_W(4)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .mispredict_valid   (mispredict_valid),
        .mispredict_rob_idx (mispredict_rob_idx),
        .mispredict_target  (mispredict_target),
        .rob_head           (rob_head),
        .rob_state          (rob_state),
        .flush_valid        (flush_valid),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .tail_restore_valid (tail_restore_valid),
        .tail_restore_idx   (tail_restore_idx),
        .walk_valid         (walk_valid),
        .walk_idx0          (walk_idx0),
        .walk_idx1          (walk_idx1)
    );

    always #5 clk = ~clk;

    // Cycle k is the interval between rising edge k and rising edge k+1.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [1:0]  st;
        logic        pulse;
        logic [31:0] pc;
        logic [3:0]  tail;
        logic [1:0]  wv;
        logic [3:0]  i0;
        logic [3:0]  i1;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push_rb(input int c, input logic [31:0] pc, input logic [3:0] tail);
        exp_t e;
        e.c = c; e.st = 2'b01; e.pulse = 1'b1; e.pc = pc; e.tail = tail;
        e.wv = 2'b00; e.i0 = 4'd0; e.i1 = 4'd0;
        exp_q.push_back(e);
    endtask

    task automatic push_wk(input int c, input logic [31:0] pc, input logic [1:0] wv,
                           input logic [3:0] i0, input logic [3:0] i1);
        exp_t e;
        e.c = c; e.st = 2'b10; e.pulse = 1'b0; e.pc = pc; e.tail = 4'd0;
        e.wv = wv; e.i0 = i0; e.i1 = i1;
        exp_q.push_back(e);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset_n && (rob_state != 2'b00 || flush_valid || redirect_valid ||
                        tail_restore_valid || walk_valid != 2'b00)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: cyc=%0d st=%0d frt=%b%b%b wv=%b i0=%0d i1=%0d, required no output",
                         cyc, rob_state, flush_valid, redirect_valid, tail_restore_valid,
                         walk_valid, walk_idx0, walk_idx1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ((cyc != e.c) || (rob_state != e.st) ||
                    (flush_valid != e.pulse) || (redirect_valid != e.pulse) ||
                    (tail_restore_valid != e.pulse) || (redirect_pc != e.pc) ||
                    (walk_valid != e.wv) ||
                    (e.pulse && (tail_restore_idx != e.tail)) ||
                    (e.wv[0] && (walk_idx0 != e.i0)) ||
                    (e.wv[1] && (walk_idx1 != e.i1))) begin
                    errors++;
                    $display("FAIL seq_output: got cyc=%0d st=%0d frt=%b%b%b pc=%h tail=%0d wv=%b i0=%0d i1=%0d; required cyc=%0d st=%0d pulse=%b pc=%h tail=%0d wv=%b i0=%0d i1=%0d",
                             cyc, rob_state, flush_valid, redirect_valid, tail_restore_valid,
                             redirect_pc, tail_restore_idx, walk_valid, walk_idx0, walk_idx1,
                             e.c, e.st, e.pulse, e.pc, e.tail, e.wv, e.i0, e.i1);
                end
            end
        end
    end

    // One-cycle mispredict; called just after a rising edge, returns the same way.
    task automatic mp(input logic [3:0] idx, input logic [31:0] tgt);
        mispredict_valid   = 1'b1;
        mispredict_rob_idx = idx;
        mispredict_target  = tgt;
        @(posedge clk); #1;
        mispredict_valid   = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bounded wait for the scoreboard to empty, plus a few trailing cycles in
    // which any further output is reported by the monitor.
    task automatic drain(input string name);
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(posedge clk);
        step(3);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: %0d expected outputs never appeared, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_cleared(input string name);
        checks++;
        if (rob_state != 2'b00 || flush_valid || redirect_valid || tail_restore_valid ||
            walk_valid != 2'b00 || redirect_pc != 32'h0 || tail_restore_idx != 4'd0 ||
            walk_idx0 != 4'd0 || walk_idx1 != 4'd0) begin
            errors++;
            $display("FAIL %s: st=%0d frt=%b%b%b pc=%h tail=%0d wv=%b i0=%0d i1=%0d, required all zero",
                     name, rob_state, flush_valid, redirect_valid, tail_restore_valid,
                     redirect_pc, tail_restore_idx, walk_valid, walk_idx0, walk_idx1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        reset_n            = 1'b0;
        mispredict_valid   = 1'b0;
        mispredict_rob_idx = 4'd0;
        mispredict_target  = 32'h0;
        rob_head           = 4'd0;
        step(2);
        check_cleared("reset_state");
        reset_n = 1'b1;
        step(2);

        // Basic: head 3, idx 6
        rob_head = 4'd3;
        c = cyc;
        push_rb(c + 1, 32'h0000_0400, 4'd7);
        push_wk(c + 2, 32'h0000_0400, 2'b11, 4'd3, 4'd4);
        push_wk(c + 3, 32'h0000_0400, 2'b11, 4'd5, 4'd6);
        mp(4'd6, 32'h0000_0400);
        step(3);   // now in the first idle cycle: zero dead cycles
        // Wrap: head 14, idx 1 -> N=4, tail 2
        rob_head = 4'd14;
        c = cyc;
        push_rb(c + 1, 32'h0000_0800, 4'd2);
        push_wk(c + 2, 32'h0000_0800, 2'b11, 4'd14, 4'd15);
        push_wk(c + 3, 32'h0000_0800, 2'b11, 4'd0, 4'd1);
        mp(4'd1, 32'h0000_0800);
        drain("basic_wrap");

        // Odd count: head 0, idx 4 -> N=5
        rob_head = 4'd0;
        c = cyc;
        push_rb(c + 1, 32'h0000_1000, 4'd5);
        push_wk(c + 2, 32'h0000_1000, 2'b11, 4'd0, 4'd1);
        push_wk(c + 3, 32'h0000_1000, 2'b11, 4'd2, 4'd3);
        push_wk(c + 4, 32'h0000_1000, 2'b01, 4'd4, 4'd0);
        mp(4'd4, 32'h0000_1000);
        drain("odd");

        // Mispredict held three cycles with the same idx -> one sequence
        rob_head = 4'd3;
        c = cyc;
        push_rb(c + 1, 32'h0000_2000, 4'd7);
        push_wk(c + 2, 32'h0000_2000, 2'b11, 4'd3, 4'd4);
        push_wk(c + 3, 32'h0000_2000, 2'b11, 4'd5, 4'd6);
        mispredict_valid   = 1'b1;
        mispredict_rob_idx = 4'd6;
        mispredict_target  = 32'h0000_2000;
        step(3);
        mispredict_valid   = 1'b0;
        drain("held");

        // Nesting: head 2, idx 10; idx 12 is dropped, idx 5 restarts
        rob_head = 4'd2;
        c = cyc;
        push_rb(c + 1, 32'h0000_3000, 4'd11);
        push_wk(c + 2, 32'h0000_3000, 2'b11, 4'd2, 4'd3);
        push_wk(c + 3, 32'h0000_3000, 2'b11, 4'd4, 4'd5);
        push_rb(c + 4, 32'h0000_3400, 4'd6);
        push_wk(c + 5, 32'h0000_3400, 2'b11, 4'd2, 4'd3);
        push_wk(c + 6, 32'h0000_3400, 2'b11, 4'd4, 4'd5);
        mp(4'd10, 32'h0000_3000);
        step(1);                      // first walk cycle
        mp(4'd12, 32'h0000_9999);     // sampled at the end of walk cycle 1
        mp(4'd5,  32'h0000_3400);     // sampled at the end of walk cycle 2
        drain("nest");

        // Full: head 5, idx 4 -> N=16, tail 5, 8 walk cycles
        rob_head = 4'd5;
        c = cyc;
        push_rb(c + 1, 32'h0000_5000, 4'd5);
        push_wk(c + 2, 32'h0000_5000, 2'b11, 4'd5,  4'd6);
        push_wk(c + 3, 32'h0000_5000, 2'b11, 4'd7,  4'd8);
        push_wk(c + 4, 32'h0000_5000, 2'b11, 4'd9,  4'd10);
        push_wk(c + 5, 32'h0000_5000, 2'b11, 4'd11, 4'd12);
        push_wk(c + 6, 32'h0000_5000, 2'b11, 4'd13, 4'd14);
        push_wk(c + 7, 32'h0000_5000, 2'b11, 4'd15, 4'd0);
        push_wk(c + 8, 32'h0000_5000, 2'b11, 4'd1,  4'd2);
        push_wk(c + 9, 32'h0000_5000, 2'b11, 4'd3,  4'd4);
        mp(4'd4, 32'h0000_5000);
        drain("full");

        // Full again, with reset asserted in the second walk cycle
        c = cyc;
        push_rb(c + 1, 32'h0000_5100, 4'd5);
        push_wk(c + 2, 32'h0000_5100, 2'b11, 4'd5, 4'd6);
        mp(4'd4, 32'h0000_5100);
        step(2);
        checks++;
        if (rob_state != 2'b10) begin
            errors++;
            $display("FAIL mid_walk_state: st=%0d, required 2", rob_state);
        end
        reset_n = 1'b0;
        #1;
        check_cleared("async_reset");
        exp_q.delete();
        step(2);
        reset_n = 1'b1;
        step(6);   // the monitor reports any output appearing here

        // Recovery after reset: head 0, idx 1
        rob_head = 4'd0;
        c = cyc;
        push_rb(c + 1, 32'h0000_6000, 4'd2);
        push_wk(c + 2, 32'h0000_6000, 2'b11, 4'd0, 4'd1);
        mp(4'd1, 32'h0000_6000);
        drain("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
